wb_lsu: RTL and testbench

Load/store unit that moves the CPU's memory phase into a dedicated Wishbone master. It accepts one load or store request per transaction, aligns byte lanes and sign-extends load data. Unlike the current in-core memory phase, it handles `err_i` and `rty_i`, retries a bounded number of times, and enforces a response timeout. It also detects misaligned accesses and reports every fault with a cause code. It sits between the core's execute/writeback sequencing and the shared Wishbone bus.

---
 rtl/wb_lsu.sv | 194 +++++++++++++++++++
 tb/tb_wb_lsu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_lsu.sv
// Wishbone load/store unit: one request at a time, byte-lane alignment, load sign/zero
// extension, bounded rty_i retries, response timeout and fault cause reporting.
module wb_lsu #(
  parameter int RETRY_LIMIT    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  output logic [31:0] dat_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        stb_o,
  output logic        cyc_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_DONE} state_t;

  localparam int RTY_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(RETRY_LIMIT);
  localparam logic [15:0]      TMO_MAX = 16'(TIMEOUT_CYCLES);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [3:0] lane_mask(input logic we, input logic [2:0] f3,
                                           input logic [1:0] a);
    if (!we) return 4'b1111;
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = req_we_i;
          f3_d    = req_funct3_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          retry_d = '0;
          tmo_d   = '0;
          fault_d = 1'b0;
          if (!funct3_legal(req_we_i, req_funct3_i)) begin
            state_d = S_DONE;
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (misaligned(req_funct3_i, req_addr_i[1:0])) begin
            state_d = S_DONE;
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (ack_i) begin
          if (!we_q) rdata_d = extend_load(f3_q, addr_q[1:0], dat_i);
          state_d = S_DONE;
        end else if (err_i) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          cause_d = CAUSE_BUSERR;
        end else if (rty_i) begin
          if (retry_q == RTY_MAX) begin
            state_d = S_DONE;
            fault_d = 1'b1;
            cause_d = CAUSE_TIMEOUT;
          end else begin
            retry_d = retry_q + 1'b1;
            tmo_d   = '0;
            state_d = S_BACKOFF;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
          // Deciding on tmo_q+1 puts the fault in the N-th silent cycle itself.
          if ((TIMEOUT_CYCLES != 0) && (tmo_q + 16'd1 == TMO_MAX)) begin
            state_d = S_DONE;
            fault_d = 1'b1;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      S_BACKOFF: state_d = S_BUS;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      retry_q <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  // Latched request only matters while busy; bus outputs are gated by state.
  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign cyc_o         = (state_q == S_BUS);
  assign stb_o         = cyc_o;
  assign we_o          = cyc_o & we_q;
  assign adr_o         = cyc_o ? {addr_q[31:2], 2'b00} : 32'd0;
  assign sel_o         = cyc_o ? lane_mask(we_q, f3_q, addr_q[1:0]) : 4'b0000;
  assign dat_o         = cyc_o ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign rdata_o       = rdata_q;
  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_wb_lsu.sv
// Directed bench for wb_lsu: stimulus pushes expected completions into a scoreboard,
// a negedge monitor pops and compares on done_o and checks bus fields every bus cycle.
module tb_wb_lsu;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0, req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        busy_o, done_o, fault_o;
  logic [31:0] rdata_o;
  logic [1:0]  fault_cause_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
  logic [31:0] dat_o, adr_o;
  logic [3:0]  sel_o;
  logic        we_o, stb_o, cyc_o;

  wb_lsu #(.RETRY_LIMIT(3), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .fault_o(fault_o),
    .fault_cause_o(fault_cause_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
    .rty_i(rty_i), .dat_o(dat_o), .adr_o(adr_o), .sel_o(sel_o), .we_o(we_o),
    .stb_o(stb_o), .cyc_o(cyc_o)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0, n_fail = 0, ndone = 0, done_cycle = 0, cyc_seen = 0;
  logic [31:0] exp_adr = '0, exp_dat = '0;
  logic [3:0]  exp_sel = '0;
  logic        exp_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      if (cyc_o) begin
        cyc_seen++;
        check("stb_o", 32'(stb_o), 32'd1);
        check("adr_o", adr_o, exp_adr);
        check("sel_o", 32'(sel_o), 32'(exp_sel));
        check("dat_o", dat_o, exp_dat);
        check("we_o", 32'(we_o), 32'(exp_we));
      end
      if (done_o) begin
        ndone++;
        done_cycle = cycle;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done_o=1 expected none (cycle %0d)", cycle);
        end else begin
          mon_e = sb_q.pop_front();
          check("fault_o", 32'(fault_o), 32'(mon_e.fault));
          if (mon_e.fault) check("fault_cause_o", 32'(fault_cause_o), 32'(mon_e.cause));
          if (mon_e.chk_rdata) check("rdata_o", rdata_o, mon_e.rdata);
        end
      end
    end
  end

  task automatic set_bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic w);
    exp_adr = a; exp_sel = s; exp_dat = d; exp_we = w;
  endtask

  task automatic expect_done(input logic [31:0] rd, input logic chk, input logic f,
                             input logic [1:0] c);
    exp_t e;
    e.rdata = rd; e.chk_rdata = chk; e.fault = f; e.cause = c;
    sb_q.push_back(e);
  endtask

  // Called at #1 after a rising edge; returns at #1 in the following cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int acc, output int nd0);
    req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd; req_i = 1'b1;
    acc = cycle;
    nd0 = ndone;
    @(posedge clk); #1;
    req_i = 1'b0;
  endtask

  task automatic respond(input logic a, input logic e, input logic r, input logic [31:0] d);
    int k = 0;
    while (!cyc_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!cyc_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL resp_wait: got cyc_o=0 expected 1 within 20 cycles");
    end
    ack_i = a; err_i = e; rty_i = r; dat_i = d;
    @(posedge clk); #1;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
  endtask

  task automatic wait_done(input int acc, input int nd0, input int lat);
    int k = 0;
    while (ndone == nd0 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    if (ndone == nd0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_wait: got no done_o expected one within 50 cycles");
    end else begin
      check("latency", 32'(done_cycle - acc), 32'(lat));
    end
    @(posedge clk); #1;
  endtask

  int acc, nd0, cs0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_fault", 32'({fault_o, fault_cause_o}), 32'd0);
    check("rst_bus_ctl", 32'({cyc_o, stb_o, we_o, sel_o}), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_adr", adr_o, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // LW, single-cycle ack
    set_bus(32'h0000_1000, 4'b1111, 32'd0, 1'b0);
    expect_done(32'hDEAD_BEEF, 1'b1, 1'b0, 2'b00);
    issue(1'b0, 3'b010, 32'h0000_1000, 32'd0, acc, nd0);
    check("busy_in_bus", 32'(busy_o), 32'd1);
    respond(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    wait_done(acc, nd0, 2);

    // LB sign extension from lane 3
    set_bus(32'h0000_1000, 4'b1111, 32'd0, 1'b0);
    expect_done(32'hFFFF_FF80, 1'b1, 1'b0, 2'b00);
    issue(1'b0, 3'b000, 32'h0000_1003, 32'd0, acc, nd0);
    respond(1'b1, 1'b0, 1'b0, 32'h80FF_FFFF);
    wait_done(acc, nd0, 2);

    // LHU upper half
    set_bus(32'h0000_2000, 4'b1111, 32'd0, 1'b0);
    expect_done(32'h0000_BEEF, 1'b1, 1'b0, 2'b00);
    issue(1'b0, 3'b101, 32'h0000_2002, 32'd0, acc, nd0);
    respond(1'b1, 1'b0, 1'b0, 32'hBEEF_1234);
    wait_done(acc, nd0, 2);

    // SB lane 1; rdata_o must keep the previous load result
    set_bus(32'h0000_3000, 4'b0010, 32'h0000_AB00, 1'b1);
    expect_done(32'h0000_BEEF, 1'b1, 1'b0, 2'b00);
    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, acc, nd0);
    respond(1'b1, 1'b0, 1'b0, 32'h1234_5678);
    wait_done(acc, nd0, 2);

    // SH upper half
    set_bus(32'h0000_2000, 4'b1100, 32'hCAFE_0000, 1'b1);
    expect_done(32'h0000_BEEF, 1'b1, 1'b0, 2'b00);
    issue(1'b1, 3'b001, 32'h0000_2002, 32'h0000_CAFE, acc, nd0);
    respond(1'b1, 1'b0, 1'b0, 32'd0);
    wait_done(acc, nd0, 2);

    // Faulted requests: done in cycle 1, no bus cycle
    cs0 = cyc_seen;
    expect_done(32'd0, 1'b0, 1'b1, 2'b00);
    issue(1'b1, 3'b001, 32'h0000_1001, 32'h0000_1234, acc, nd0);
    wait_done(acc, nd0, 1);
    expect_done(32'd0, 1'b0, 1'b1, 2'b00);
    issue(1'b0, 3'b010, 32'h0000_1002, 32'd0, acc, nd0);
    wait_done(acc, nd0, 1);
    expect_done(32'd0, 1'b0, 1'b1, 2'b01);
    issue(1'b1, 3'b100, 32'h0000_1000, 32'd0, acc, nd0);
    wait_done(acc, nd0, 1);
    expect_done(32'd0, 1'b0, 1'b1, 2'b01);
    issue(1'b0, 3'b011, 32'h0000_1001, 32'd0, acc, nd0);
    wait_done(acc, nd0, 1);
    check("no_cyc_on_fault", 32'(cyc_seen - cs0), 32'd0);

    // Two retries then ack: one BACKOFF cycle after each rty_i
    set_bus(32'h0000_4000, 4'b1111, 32'd0, 1'b0);
    expect_done(32'hFFFF_8001, 1'b1, 1'b0, 2'b00);
    issue(1'b0, 3'b001, 32'h0000_4002, 32'd0, acc, nd0);
    respond(1'b0, 1'b0, 1'b1, 32'd0);
    check("backoff1_cyc", 32'(cyc_o), 32'd0);
    @(posedge clk); #1;
    check("rebus1_cyc", 32'(cyc_o), 32'd1);
    respond(1'b0, 1'b0, 1'b1, 32'd0);
    check("backoff2_cyc", 32'(cyc_o), 32'd0);
    @(posedge clk); #1;
    check("rebus2_cyc", 32'(cyc_o), 32'd1);
    respond(1'b1, 1'b0, 1'b0, 32'h8001_0000);
    wait_done(acc, nd0, 6);

    // Four rty_i with limit 3: faults right after the fourth
    set_bus(32'h0000_5000, 4'b1111, 32'd0, 1'b0);
    expect_done(32'd0, 1'b0, 1'b1, 2'b11);
    issue(1'b0, 3'b010, 32'h0000_5000, 32'd0, acc, nd0);
    for (int i = 0; i < 4; i++) respond(1'b0, 1'b0, 1'b1, 32'd0);
    wait_done(acc, nd0, 8);

    // err_i beats rty_i
    set_bus(32'h0000_5004, 4'b1111, 32'd0, 1'b0);
    expect_done(32'd0, 1'b0, 1'b1, 2'b10);
    issue(1'b0, 3'b010, 32'h0000_5004, 32'd0, acc, nd0);
    respond(1'b0, 1'b1, 1'b1, 32'd0);
    wait_done(acc, nd0, 2);

    // ack_i beats err_i; LBU lane 2
    set_bus(32'h0000_6000, 4'b1111, 32'd0, 1'b0);
    expect_done(32'h0000_00F2, 1'b1, 1'b0, 2'b00);
    issue(1'b0, 3'b100, 32'h0000_6002, 32'd0, acc, nd0);
    respond(1'b1, 1'b1, 1'b0, 32'h11F2_3344);
    wait_done(acc, nd0, 2);

    // Timeout after 4 silent cycles
    set_bus(32'h0000_7000, 4'b1111, 32'd0, 1'b0);
    expect_done(32'd0, 1'b0, 1'b1, 2'b11);
    issue(1'b0, 3'b010, 32'h0000_7000, 32'd0, acc, nd0);
    wait_done(acc, nd0, 5);

    // Reset in the second BUS cycle
    set_bus(32'h0000_8000, 4'b1111, 32'd0, 1'b0);
    issue(1'b0, 3'b010, 32'h0000_8000, 32'd0, acc, nd0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_cyc", 32'(cyc_o), 32'd0);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_done", 32'(ndone), 32'(nd0));

    set_bus(32'h0000_9000, 4'b1111, 32'd0, 1'b0);
    expect_done(32'h0BAD_F00D, 1'b1, 1'b0, 2'b00);
    issue(1'b0, 3'b010, 32'h0000_9000, 32'd0, acc, nd0);
    respond(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    wait_done(acc, nd0, 2);

    // Responses while idle are ignored
    nd0 = ndone;
    ack_i = 1'b1; err_i = 1'b1; rty_i = 1'b1; dat_i = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_resp_no_done", 32'(ndone), 32'(nd0));
    check("idle_resp_rdata", rdata_o, 32'h0BAD_F00D);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
